// File: rtl/i3c_pkg.sv
// rtl/i3c_pkg.sv - shared types and constants for the I3C bus front end
package i3c_pkg;

  // Idle level of an open-drain I3C line; used for sync flops and filtered outputs on reset.
  localparam logic LINE_RESET_LEVEL = 1'b1;

  typedef struct packed {
    logic scl_pos;
    logic scl_neg;
    logic sda_pos;
    logic sda_neg;
    logic start;
    logic stop;
  } bus_events_t;

endpackage

// File: rtl/i3c_line_filter.sv
// rtl/i3c_line_filter.sv - per-line synchronizer, glitch filter and edge pulses
module i3c_line_filter
  import i3c_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int FilterCntW = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  line_i,
  input  logic                  filter_en_i,
  input  logic [FilterCntW-1:0] filter_cycles_i,
  output logic                  line_o,
  output logic                  posedge_o,
  output logic                  negedge_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  s;
  logic                  filt_q;
  logic                  filt_next;
  logic [FilterCntW-1:0] cnt_q;
  logic [FilterCntW-1:0] cnt_next;
  logic [FilterCntW:0]   cnt_inc;
  logic                  bypass;

  assign s       = sync_q[SyncStages-1];
  assign bypass  = !filter_en_i || (filter_cycles_i == '0);
  assign cnt_inc = {1'b0, cnt_q} + {{FilterCntW{1'b0}}, 1'b1};

  // The >= compare lets a lowered threshold complete an in-progress count at once.
  always_comb begin
    filt_next = filt_q;
    cnt_next  = '0;
    if (bypass) begin
      filt_next = s;
    end else if (s != filt_q) begin
      if (cnt_inc >= {1'b0, filter_cycles_i}) begin
        filt_next = s;
      end else begin
        cnt_next = cnt_inc[FilterCntW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= {SyncStages{LINE_RESET_LEVEL}};
      filt_q    <= LINE_RESET_LEVEL;
      cnt_q     <= '0;
      posedge_o <= 1'b0;
      negedge_o <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SyncStages-2:0], line_i};
      filt_q    <= filt_next;
      cnt_q     <= cnt_next;
      posedge_o <= filt_next & ~filt_q;
      negedge_o <= ~filt_next & filt_q;
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/i3c_bus_input_filter.sv
// rtl/i3c_bus_input_filter.sv - filtered SCL/SDA with START/STOP decode and bus-idle detect
module i3c_bus_input_filter
  import i3c_pkg::*;
#(
  parameter int SyncStages = 2,
  parameter int FilterCntW = 4,
  parameter int IdleCntW   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  input  logic                  filter_en_i,
  input  logic [FilterCntW-1:0] filter_cycles_i,
  input  logic [IdleCntW-1:0]   idle_cycles_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic                  scl_posedge_o,
  output logic                  scl_negedge_o,
  output logic                  sda_posedge_o,
  output logic                  sda_negedge_o,
  output logic                  start_det_o,
  output logic                  stop_det_o,
  output logic                  bus_idle_o
);

  bus_events_t         events;
  logic [IdleCntW-1:0] idle_cnt;
  logic                idle_gate;
  logic                scl_edge;

  i3c_line_filter #(.SyncStages(SyncStages), .FilterCntW(FilterCntW)) u_scl_filter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .line_i          (scl_i),
    .filter_en_i     (filter_en_i),
    .filter_cycles_i (filter_cycles_i),
    .line_o          (scl_o),
    .posedge_o       (events.scl_pos),
    .negedge_o       (events.scl_neg)
  );

  i3c_line_filter #(.SyncStages(SyncStages), .FilterCntW(FilterCntW)) u_sda_filter (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .line_i          (sda_i),
    .filter_en_i     (filter_en_i),
    .filter_cycles_i (filter_cycles_i),
    .line_o          (sda_o),
    .posedge_o       (events.sda_pos),
    .negedge_o       (events.sda_neg)
  );

  // Simultaneous SCL/SDA movement is ambiguous and never decoded as a bus condition.
  assign scl_edge     = events.scl_pos | events.scl_neg;
  assign events.start = events.sda_neg & scl_o & ~scl_edge;
  assign events.stop  = events.sda_pos & scl_o & ~scl_edge;

  // idle_gate keeps bus_idle_o low on reset exit and for the cycle after a START.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt  <= '0;
      idle_gate <= 1'b0;
    end else begin
      idle_gate <= ~events.start;
      if (events.start || !(scl_o && sda_o)) begin
        idle_cnt <= '0;
      end else if (idle_cnt != '1) begin
        idle_cnt <= idle_cnt + {{(IdleCntW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus_idle_o    = scl_o & sda_o & idle_gate & (idle_cnt >= idle_cycles_i);
  assign scl_posedge_o = events.scl_pos;
  assign scl_negedge_o = events.scl_neg;
  assign sda_posedge_o = events.sda_pos;
  assign sda_negedge_o = events.sda_neg;
  assign start_det_o   = events.start;
  assign stop_det_o    = events.stop;

endmodule
